// File: rtl/cvp_pwr_arbiter.sv
// Round-robin arbiter sharing one CVP 4-phase req/ack channel among NUM_REQ requesters.
// Synchronises the async ack, captures read data/error and bounds each transaction with a timeout.
module cvp_pwr_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [NUM_REQ-1:0]      m_req,
  input  logic [NUM_REQ-1:0]      m_wr_rd,
  input  logic [NUM_REQ*29-1:0]   m_add,
  input  logic [NUM_REQ*8-1:0]    m_be,
  input  logic [NUM_REQ*64-1:0]   m_wdata,
  output logic [NUM_REQ-1:0]      m_done,
  output logic [63:0]             m_rdata,
  output logic                    m_error,
  output logic                    m_timeout,
  output logic                    cvp_pwr_req,
  output logic                    cvp_pwr_wr_rd,
  output logic [28:0]             cvp_pwr_add,
  output logic [7:0]              cvp_pwr_be,
  output logic [63:0]             cvp_pwr_data,
  input  logic                    cvp_pwr_ack,
  input  logic                    cvp_pwr_error,
  input  logic [63:0]             cvp_pwr_r_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned AW    = 29;
  localparam int unsigned BW    = 8;
  localparam int unsigned DW    = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_meta, ack_sync;
  logic [NUM_REQ-1:0]   req_q;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]     winner, winner_d;
  logic [TO_CNT_W-1:0]  to_cnt, to_cnt_d;

  logic [NUM_REQ-1:0]   done_d;
  logic [DW-1:0]        rdata_d;
  logic                 error_d, timeout_d;
  logic                 req_d, wr_rd_d;
  logic [AW-1:0]        add_d;
  logic [BW-1:0]        be_d;
  logic [DW-1:0]        data_d;

  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx, scan_idx;
  logic                 sel_wr_rd;
  logic [AW-1:0]        sel_add;
  logic [BW-1:0]        sel_be;
  logic [DW-1:0]        sel_data;

  // Round-robin scan from rr_ptr upward with wrap, then mux the winner's fields.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    sel_wr_rd = 1'b0;
    sel_add   = '0;
    sel_be    = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!grant_vld && req_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == grant_idx) begin
        sel_wr_rd = m_wr_rd[i];
        sel_add   = m_add[i*AW +: AW];
        sel_be    = m_be[i*BW +: BW];
        sel_data  = m_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr;
    winner_d  = winner;
    to_cnt_d  = to_cnt;
    done_d    = '0;
    rdata_d   = m_rdata;
    error_d   = m_error;
    timeout_d = m_timeout;
    req_d     = cvp_pwr_req;
    wr_rd_d   = cvp_pwr_wr_rd;
    add_d     = cvp_pwr_add;
    be_d      = cvp_pwr_be;
    data_d    = cvp_pwr_data;

    unique case (state_q)
      ST_IDLE: begin
        // ack_meta also gates so a still-high ack right after reset cannot slip a grant through.
        if (grant_vld && !ack_sync && !ack_meta) begin
          winner_d = grant_idx;
          req_d    = 1'b1;
          wr_rd_d  = sel_wr_rd;
          add_d    = sel_add;
          be_d     = sel_be;
          data_d   = sel_data;
          to_cnt_d = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        to_cnt_d = to_cnt + TO_CNT_W'(1);
        if (ack_sync || (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1))) begin
          done_d    = NUM_REQ'(1) << winner;
          rdata_d   = ack_sync ? cvp_pwr_r_data : '0;
          error_d   = ack_sync ? cvp_pwr_error : 1'b1;
          timeout_d = !ack_sync;
          req_d     = 1'b0;
          wr_rd_d   = 1'b0;
          add_d     = '0;
          be_d      = '0;
          data_d    = '0;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_sync) begin
          rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, synchroniser and output registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ST_IDLE;
      ack_meta      <= 1'b0;
      ack_sync      <= 1'b0;
      req_q         <= '0;
      rr_ptr        <= '0;
      winner        <= '0;
      to_cnt        <= '0;
      m_done        <= '0;
      m_rdata       <= '0;
      m_error       <= 1'b0;
      m_timeout     <= 1'b0;
      cvp_pwr_req   <= 1'b0;
      cvp_pwr_wr_rd <= 1'b0;
      cvp_pwr_add   <= '0;
      cvp_pwr_be    <= '0;
      cvp_pwr_data  <= '0;
    end else begin
      state_q       <= state_d;
      ack_meta      <= cvp_pwr_ack;
      ack_sync      <= ack_meta;
      req_q         <= m_req;
      rr_ptr        <= rr_ptr_d;
      winner        <= winner_d;
      to_cnt        <= to_cnt_d;
      m_done        <= done_d;
      m_rdata       <= rdata_d;
      m_error       <= error_d;
      m_timeout     <= timeout_d;
      cvp_pwr_req   <= req_d;
      cvp_pwr_wr_rd <= wr_rd_d;
      cvp_pwr_add   <= add_d;
      cvp_pwr_be    <= be_d;
      cvp_pwr_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_cvp_pwr_arbiter.sv
// Directed bench for cvp_pwr_arbiter: two requesters, TIMEOUT_CYCLES=16, CVP modelled inline.
module tb_cvp_pwr_arbiter;

  logic         HCLK;
  logic         HRESET;
  logic [1:0]   m_req;
  logic [1:0]   m_wr_rd;
  logic [57:0]  m_add;
  logic [15:0]  m_be;
  logic [127:0] m_wdata;
  logic [1:0]   m_done;
  logic [63:0]  m_rdata;
  logic         m_error;
  logic         m_timeout;
  logic         cvp_pwr_req;
  logic         cvp_pwr_wr_rd;
  logic [28:0]  cvp_pwr_add;
  logic [7:0]   cvp_pwr_be;
  logic [63:0]  cvp_pwr_data;
  logic         cvp_pwr_ack;
  logic         cvp_pwr_error;
  logic [63:0]  cvp_pwr_r_data;

  int checks   = 0;
  int failures = 0;

  cvp_pwr_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_req(m_req), .m_wr_rd(m_wr_rd), .m_add(m_add), .m_be(m_be), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata), .m_error(m_error), .m_timeout(m_timeout),
    .cvp_pwr_req(cvp_pwr_req), .cvp_pwr_wr_rd(cvp_pwr_wr_rd), .cvp_pwr_add(cvp_pwr_add),
    .cvp_pwr_be(cvp_pwr_be), .cvp_pwr_data(cvp_pwr_data),
    .cvp_pwr_ack(cvp_pwr_ack), .cvp_pwr_error(cvp_pwr_error), .cvp_pwr_r_data(cvp_pwr_r_data)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!cvp_pwr_req && n < 50) begin
      tick;
      n++;
    end
    chk(tag, 64'(cvp_pwr_req), 64'd1);
  endtask

  // CVP model: wait for req, ack after dly cycles, return when m_done seen (bounded).
  task automatic serve(input string tag, input int dly, input logic err, input logic [63:0] rd,
                       output logic [1:0] done_v, output int lat);
    wait_req(tag);
    repeat (dly) tick;
    cvp_pwr_ack    = 1'b1;
    cvp_pwr_error  = err;
    cvp_pwr_r_data = rd;
    lat = 0;
    do begin
      tick;
      lat++;
    end while (m_done == 2'b00 && lat < 20);
    done_v         = m_done;
    cvp_pwr_ack    = 1'b0;
    cvp_pwr_error  = 1'b0;
    cvp_pwr_r_data = '0;
  endtask

  initial begin
    logic [1:0]  done_v;
    logic [63:0] rd_exp;
    int          lat;
    int          cnt;
    logic        seen;

    HRESET = 1'b1;
    m_req = '0; m_wr_rd = '0; m_add = '0; m_be = '0; m_wdata = '0;
    cvp_pwr_ack = 1'b0; cvp_pwr_error = 1'b0; cvp_pwr_r_data = '0;
    repeat (3) tick;
    chk("rst_req",     64'(cvp_pwr_req), 64'd0);
    chk("rst_done",    64'(m_done),      64'd0);
    chk("rst_rdata",   m_rdata,          64'd0);
    chk("rst_error",   64'(m_error),     64'd0);
    chk("rst_timeout", 64'(m_timeout),   64'd0);
    chk("rst_add",     64'(cvp_pwr_add), 64'd0);
    HRESET = 1'b0;
    tick;

    // Single write from requester 0
    m_req        = 2'b01;
    m_wr_rd      = 2'b00;
    m_add[28:0]  = 29'h15;
    m_be[7:0]    = 8'hF0;
    m_wdata[63:0] = 64'hDEADBEEF_00000000;
    tick;
    chk("wr_req_lat1", 64'(cvp_pwr_req), 64'd0);
    tick;
    chk("wr_req_lat2", 64'(cvp_pwr_req),   64'd1);
    chk("wr_wr_rd",    64'(cvp_pwr_wr_rd), 64'd0);
    chk("wr_add",      64'(cvp_pwr_add),   64'h15);
    chk("wr_be",       64'(cvp_pwr_be),    64'hF0);
    chk("wr_data",     cvp_pwr_data,       64'hDEADBEEF_00000000);
    serve("wr_grant", 5, 1'b0, 64'h1111_2222_3333_4444, done_v, lat);
    chk("wr_done",     64'(done_v),        64'd1);
    chk("wr_lat",      64'(lat),           64'd3);
    chk("wr_error",    64'(m_error),       64'd0);
    chk("wr_timeout",  64'(m_timeout),     64'd0);
    chk("wr_rdata",    m_rdata,            64'h1111_2222_3333_4444);
    chk("wr_req_drop", 64'(cvp_pwr_req),   64'd0);
    chk("wr_add_clr",  64'(cvp_pwr_add),   64'd0);
    chk("wr_data_clr", cvp_pwr_data,       64'd0);
    m_req = 2'b00;
    tick;
    chk("wr_done_pulse", 64'(m_done), 64'd0);
    repeat (4) tick;

    // Read from requester 1 with CVP error
    m_req         = 2'b10;
    m_wr_rd       = 2'b10;
    m_add[57:29]  = 29'h0ABCDEF;
    m_be[15:8]    = 8'h0F;
    repeat (2) tick;
    chk("rd_wr_rd", 64'(cvp_pwr_wr_rd), 64'd1);
    chk("rd_add",   64'(cvp_pwr_add),   64'h0ABCDEF);
    chk("rd_be",    64'(cvp_pwr_be),    64'h0F);
    serve("rd_grant", 2, 1'b1, 64'h01234567_89ABCDEF, done_v, lat);
    chk("rd_done",    64'(done_v),    64'd2);
    chk("rd_rdata",   m_rdata,        64'h01234567_89ABCDEF);
    chk("rd_error",   64'(m_error),   64'd1);
    chk("rd_timeout", 64'(m_timeout), 64'd0);
    m_req = 2'b00;
    m_wr_rd = 2'b00;
    repeat (5) tick;

    // Both requesters continuously requesting: strict alternation from 0
    m_req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      rd_exp = 64'h0000_00A0_0000_0000 + 64'(k);
      serve("rr_grant", 1, 1'b0, rd_exp, done_v, lat);
      chk("rr_order", 64'(done_v), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_rdata", m_rdata, rd_exp);
    end
    m_req = 2'b00;
    repeat (5) tick;

    // No ack: timeout after exactly 16 REQ cycles
    m_req = 2'b01;
    wait_req("to_grant");
    cnt = 0;
    while (cvp_pwr_req && cnt < 100) begin
      cnt++;
      tick;
    end
    chk("to_cycles",  64'(cnt),       64'd16);
    chk("to_done",    64'(m_done),    64'd1);
    chk("to_error",   64'(m_error),   64'd1);
    chk("to_timeout", 64'(m_timeout), 64'd1);
    chk("to_rdata",   m_rdata,        64'd0);
    m_req = 2'b00;
    tick;
    m_req = 2'b10;
    serve("to_next_grant", 3, 1'b0, 64'hA5A5, done_v, lat);
    chk("to_next_done",    64'(done_v),    64'd2);
    chk("to_next_timeout", 64'(m_timeout), 64'd0);
    chk("to_next_error",   64'(m_error),   64'd0);
    m_req = 2'b00;
    repeat (5) tick;

    // ack_sync rises on the last counted cycle: ack wins
    m_req = 2'b01;
    serve("co_grant", 13, 1'b0, 64'h5555_AAAA_0000_1234, done_v, lat);
    chk("co_done",    64'(done_v),    64'd1);
    chk("co_timeout", 64'(m_timeout), 64'd0);
    chk("co_error",   64'(m_error),   64'd0);
    chk("co_rdata",   m_rdata,        64'h5555_AAAA_0000_1234);
    m_req = 2'b00;
    repeat (5) tick;

    // Reset in REQ while ack is high; no grant until ack falls
    m_req = 2'b01;
    wait_req("rs_grant");
    cvp_pwr_ack = 1'b1;
    tick;
    HRESET = 1'b1;
    tick;
    chk("rs_req_drop", 64'(cvp_pwr_req), 64'd0);
    chk("rs_done",     64'(m_done),      64'd0);
    HRESET = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (cvp_pwr_req) seen = 1'b1;
    end
    chk("rs_blocked", 64'(seen), 64'd0);
    cvp_pwr_ack = 1'b0;
    serve("rs_regrant", 2, 1'b0, 64'h77, done_v, lat);
    chk("rs_done_after", 64'(done_v), 64'd1);
    m_req = 2'b00;
    repeat (5) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
